mealy_fsm: RTL and testbench



---
 rtl/mealy_fsm.sv | 57 +++++
 tb/tb_mealy_fsm.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/mealy_fsm.sv
`default_nettype none
// ============================================================================
// Module      : mealy_fsm
// Description : Mealy "101" serial sequence detector with optional overlap.
// Revision    : 1.0 - initial release
// ============================================================================
module mealy_fsm #(
    parameter int OVERLAP = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic       y,
    output logic [1:0] PS_out
);

    localparam logic [1:0] S0 = 2'b00;
    localparam logic [1:0] S1 = 2'b01;
    localparam logic [1:0] S2 = 2'b10;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       y_d;

    always_comb begin
        state_d = S0;
        y_d     = 1'b0;
        case (state_q)
            S0: state_d = din ? S1 : S0;
            S1: state_d = din ? S1 : S2;
            S2: begin
                // The trailing '1' of a match seeds the next one only when overlapping.
                if (din) begin
                    y_d     = 1'b1;
                    state_d = (OVERLAP != 0) ? S1 : S0;
                end else begin
                    state_d = S0;
                end
            end
            default: state_d = S0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    // Detect is suppressed while reset is asserted, even before the reset edge.
    assign y      = y_d & rst;
    assign PS_out = state_q;

endmodule
`default_nettype wire

// File: tb/tb_mealy_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_mealy_fsm
// Description : Scoreboard bench for mealy_fsm, both overlap modes side by side.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mealy_fsm;

    logic       clk;
    logic       rst;
    logic       din;
    logic       y_ov;
    logic       y_no;
    logic [1:0] ps_ov;
    logic [1:0] ps_no;

    typedef struct {
        int         idx;
        bit         chk_ps;
        logic       y_ov;
        logic [1:0] ps_ov;
        logic       y_no;
        logic [1:0] ps_no;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp;
    int   n_bad;
    int   n_step;

    mealy_fsm #(.OVERLAP(1)) u_dut_ov (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .y      (y_ov),
        .PS_out (ps_ov)
    );

    mealy_fsm #(.OVERLAP(0)) u_dut_no (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .y      (y_no),
        .PS_out (ps_no)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_bit(input int idx, input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL cycle %0d %s: got %b expected %b", idx, nm, act, exp);
        end
    endtask

    task automatic check_ps(input int idx, input string nm, input logic [1:0] act, input logic [1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL cycle %0d %s: got %b expected %b", idx, nm, act, exp);
        end
    endtask

    // Expected values describe what must be visible during the cycle the inputs are applied.
    task automatic step(input logic r, input logic d, input bit cps,
                        input logic eyo, input logic [1:0] epo,
                        input logic eyn, input logic [1:0] epn);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r;
        din = d;
        e.idx    = n_step;
        e.chk_ps = cps;
        e.y_ov   = eyo;
        e.ps_ov  = epo;
        e.y_no   = eyn;
        e.ps_no  = epn;
        exp_q.push_back(e);
        n_step++;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_bit(e.idx, "y_ov", y_ov, e.y_ov);
            check_bit(e.idx, "y_no", y_no, e.y_no);
            if (e.chk_ps) begin
                check_ps(e.idx, "ps_ov", ps_ov, e.ps_ov);
                check_ps(e.idx, "ps_no", ps_no, e.ps_no);
            end
        end
    end

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        n_step = 0;
        rst    = 1'b0;
        din    = 1'b0;

        // Reset held with din toggling
        step(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 2'b00);
        step(1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
        // Match then overlap/non-overlap divergence: din 1,0,1,0,1,0,0
        step(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
        step(1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 2'b01);
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 2'b10);
        step(1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 2'b00);
        step(1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 2'b01);
        step(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 2'b10);
        // Near misses: din 1,1,0,0,1,1
        step(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 2'b01);
        step(1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 2'b01);
        step(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 2'b10);
        step(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, 2'b01);
        // Reach S2, then reset while din=1
        step(1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 2'b01);
        step(1'b0, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 2'b10);
        // Release: 0,1 must not detect, then a fresh full 1,0,1 does
        step(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
        step(1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0, 2'b00);
        step(1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 2'b01);
        step(1'b1, 1'b1, 1'b1, 1'b1, 2'b10, 1'b1, 2'b10);
        step(1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 2'b00);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
